pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction-fetch stage.
- Generates the 16-bit address for the single-clock synchronous instruction ROM (32-bit wide, 1-cycle read latency).
- Tracks which PC the ROM output currently belongs to, so the ROM `q` and the PC tag stay aligned.
- Handles decode stall, branch redirect from EX, and a HALT instruction; decode uses `if_valid` to insert bubbles.

Parameters:
- PC_W, 16, width of the program counter and ROM address.
- RESET_PC, 16'h0000, first fetch address after reset.
- HALT_WORD, 32'hFFFF_FFFF, full instruction word that halts fetch.

Ports:
- clk  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept; hold the current instruction on `instr_q`.
- redirect  in  1  taken branch or jump from EX; flush and refetch.
- redirect_pc  in  PC_W  branch target address.
- resume  in  1  leave HALT.
- instr_q  in  32  ROM `q` output (word at the address presented on the previous cycle).
- pc  out  PC_W  ROM address, combinational.
- if_pc  out  PC_W  address of the word currently on `instr_q`.
- if_valid  out  1  `instr_q` is a real, in-path instruction.
- halted  out  1  FSM is in HALT.

Behaviour:
- Internal registers:
  - `pc_r`: next sequential address.
  - `if_pc_r`: tag for `instr_q`.
  - `valid_r`.
  - `state` ∈ {RUN, HALT}.
- Reset (async, any time, including mid-redirect or mid-HALT):
  - `pc_r` = RESET_PC, `if_pc_r` = RESET_PC, `valid_r` = 0, `state` = RUN.
  - Outputs during reset: `pc` = RESET_PC, `if_pc` = RESET_PC, `if_valid` = 0, `halted` = 0.
- `pc` mux, priority order:
  1. `redirect` → `redirect_pc`.
  2. `state` == HALT → `pc_r`.
  3. `stall` → `if_pc_r`. This re-reads the same word so `instr_q` is unchanged next cycle.
  4. Otherwise → `pc_r`.
- `if_valid` = `valid_r` & ~`redirect` & (`state` == RUN). A wrong-path word is invalid in the redirect cycle itself.
- `if_pc` = `if_pc_r`.
- Clock-edge updates, in priority order:
  - `redirect`:
    - `if_pc_r` ← `redirect_pc`; `pc_r` ← `redirect_pc` + 1; `valid_r` ← 1; `state` ← RUN.
    - Overrides `stall`, HALT and halt detection.
  - HALT & `resume`: `if_pc_r` ← `pc_r`; `pc_r` ← `pc_r` + 1; `valid_r` ← 1; `state` ← RUN.
  - HALT & ~`resume`: hold all registers. `stall` is ignored.
  - RUN & `stall`: hold all registers.
  - RUN & `valid_r` & `instr_q` == HALT_WORD:
    - `state` ← HALT; `valid_r` ← 0.
    - `pc_r` and `if_pc_r` held, so `pc_r` = HALT address + 1.
  - RUN otherwise: `if_pc_r` ← `pc_r`; `pc_r` ← `pc_r` + 1; `valid_r` ← 1.
- Latency:
  - Address presented in cycle t → `instr_q` and `if_pc` match it in cycle t+1.
  - First valid instruction appears 1 cycle after reset release.
  - Redirect costs 1 bubble.
- HALT word:
  - Reported valid for exactly one cycle.
  - Not refetched on resume; execution continues at HALT address + 1.
- `resume` while in RUN: ignored.
- Wrap-around: `pc_r` increments modulo 2^PC_W (16'hFFFF + 1 = 16'h0000); no fault raised. `redirect_pc` + 1 wraps the same way.
- Stall and redirect in the same cycle: redirect wins; `stall` is ignored that cycle.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- When defined, adds two outputs:
  - `fetch_count` (out, 32): increments on every edge where `if_valid` & ~`stall`.
  - `stall_count` (out, 32): increments on every edge where `state` == RUN & `stall` & ~`redirect`.
  - Both counters clear to 0 on reset and wrap at 2^32.
- When not defined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with ROM word = address → `pc` = 0 during reset; cycle 1: `if_pc` = 0, `if_valid` = 1; cycle 4: `if_pc` = 3, `pc` = 4.
- `stall` high for 3 cycles while `if_pc` = 5 → `pc` = 5, `if_pc` = 5, `instr_q` = word 5 throughout; after release `if_pc` = 6 on the next cycle, with no word skipped or duplicated.
- `redirect` = 1, `redirect_pc` = 16'h0040 while at `if_pc` = 7 → `if_valid` = 0 that cycle; next cycle `if_pc` = 16'h0040, `if_valid` = 1, `pc` = 16'h0041.
- HALT_WORD at address 9 → `if_valid` = 1 for word 9 once, then `halted` = 1, `if_valid` = 0 for 10 cycles; `resume` pulse → next cycle `if_pc` = 10, `if_valid` = 1.
- `redirect_pc` = 16'hFFFF → `if_pc` = 16'hFFFF, then 16'h0000, then 16'h0001; `stall` + `redirect` in the same cycle → redirect taken.
- Async `resetn` low mid-HALT (and mid-stall) → `halted` = 0, `if_valid` = 0, `pc` = RESET_PC immediately, without waiting for a clock edge. With PC_FETCH_PERF_EN, 5 fetches + 2 stall cycles → `fetch_count` = 5, `stall_count` = 2.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding a 1-cycle synchronous instruction ROM.
// Optional perf counters (fetch_count, stall_count) are built when PC_FETCH_PERF_EN is defined.
module pc_fetch_ctrl #(
   parameter int unsigned        PC_W      = 16,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [31:0]        HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            resume,
   input  logic [31:0]     instr_q,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] if_pc,
   output logic            if_valid,
   output logic            halted
`ifdef PC_FETCH_PERF_EN
   ,output logic [31:0]    fetch_count,
   output logic [31:0]     stall_count
`endif
);

   typedef enum logic {S_RUN, S_HALT} state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] if_pc_q;
   logic            valid_q;

   // A stalled fetch re-reads the tagged word so instr_q stays put for decode.
   always_comb begin
      pc = pc_q;
      if (redirect)
         pc = redirect_pc;
      else if (state_q == S_HALT)
         pc = pc_q;
      else if (stall)
         pc = if_pc_q;
   end

   assign if_pc    = if_pc_q;
   assign if_valid = valid_q & ~redirect & (state_q == S_RUN);
   assign halted   = (state_q == S_HALT);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         if_pc_q <= RESET_PC;
         valid_q <= 1'b0;
      end else if (redirect) begin
         state_q <= S_RUN;
         if_pc_q <= redirect_pc;
         pc_q    <= redirect_pc + PC_ONE;
         valid_q <= 1'b1;
      end else if (state_q == S_HALT) begin
         if (resume) begin
            state_q <= S_RUN;
            if_pc_q <= pc_q;
            pc_q    <= pc_q + PC_ONE;
            valid_q <= 1'b1;
         end
      end else if (!stall) begin
         if (valid_q && instr_q == HALT_WORD) begin
            // pc_q already points past the halt word, which is where resume continues.
            state_q <= S_HALT;
            valid_q <= 1'b0;
         end else begin
            if_pc_q <= pc_q;
            pc_q    <= pc_q + PC_ONE;
            valid_q <= 1'b1;
         end
      end
   end

`ifdef PC_FETCH_PERF_EN
   logic [31:0] fetch_count_q;
   logic [31:0] stall_count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (if_valid && !stall)
            fetch_count_q <= fetch_count_q + 32'd1;
         if (state_q == S_RUN && stall && !redirect)
            stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: ROM model, instruction-stream reference model checked every
// cycle, directed scenarios with literal expectations, then randomized stimulus.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stall, redirect, resume;
   logic [15:0] redirect_pc;
   logic [31:0] instr_q = 32'h0;
   logic [15:0] pc, if_pc;
   logic        if_valid, halted;
`ifdef PC_FETCH_PERF_EN
   logic [31:0] fetch_count, stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_ctrl dut (
      .clk(clk), .resetn(resetn), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .resume(resume), .instr_q(instr_q),
      .pc(pc), .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
`ifdef PC_FETCH_PERF_EN
      , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // ROM contents: word = address, with halt words at a few fixed addresses.
   function automatic logic [31:0] rom(input logic [15:0] a);
      if (a == 16'h0009 || a == 16'h0031 || a == 16'h0055) return 32'hFFFF_FFFF;
      return {16'h0000, a};
   endfunction

   always @(posedge clk) instr_q <= rom(pc);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks the in-path instruction stream, not the RTL registers.
   logic [15:0] m_addr;    // address of the next in-path instruction to deliver
   bit          m_ready;   // an in-path word is (or should be) on instr_q
   bit          m_halt;
   bit          prev_ok;
   logic [15:0] prev_pc;
   int unsigned m_fetch, m_stall;

   always @(negedge clk) begin
      bit          ev;
      logic [15:0] nxt;
      if (!resetn) begin
         chk("rst_pc", {16'h0, pc}, 32'h0);
         chk("rst_if_pc", {16'h0, if_pc}, 32'h0);
         chk("rst_valid", {31'h0, if_valid}, 32'h0);
         chk("rst_halted", {31'h0, halted}, 32'h0);
         m_addr = 16'h0; m_ready = 0; m_halt = 0; prev_ok = 0;
         m_fetch = 0; m_stall = 0;
      end else begin
         ev  = m_ready && !redirect && !m_halt;
         nxt = m_addr + 16'd1;
         chk("halted", {31'h0, halted}, {31'h0, m_halt});
         chk("if_valid", {31'h0, if_valid}, {31'h0, ev});
         if (ev) begin
            chk("if_pc_stream", {16'h0, if_pc}, {16'h0, m_addr});
            chk("instr_align", instr_q, rom(m_addr));
            if (prev_ok) chk("if_pc_vs_prev_pc", {16'h0, if_pc}, {16'h0, prev_pc});
         end
         if (redirect)      chk("pc_redirect", {16'h0, pc}, {16'h0, redirect_pc});
         else if (m_halt)   chk("pc_halt", {16'h0, pc}, {16'h0, m_addr});
         else if (stall)    chk("pc_stall", {16'h0, pc}, {16'h0, if_pc});
         else if (m_ready)  chk("pc_seq", {16'h0, pc}, {16'h0, nxt});
         else               chk("pc_first", {16'h0, pc}, {16'h0, m_addr});
`ifdef PC_FETCH_PERF_EN
         chk("fetch_count", fetch_count, m_fetch);
         chk("stall_count", stall_count, m_stall);
         if (ev && !stall) m_fetch++;
         if (!m_halt && stall && !redirect) m_stall++;
`endif
         prev_pc = pc; prev_ok = 1;
         if (redirect) begin
            m_addr = redirect_pc; m_ready = 1; m_halt = 0;
         end else if (m_halt) begin
            if (resume) begin m_ready = 1; m_halt = 0; end
         end else if (!stall) begin
            if (m_ready) begin
               if (rom(m_addr) == 32'hFFFF_FFFF) begin m_halt = 1; m_ready = 0; end
               m_addr = nxt;
            end else m_ready = 1;
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   initial begin
      resetn = 0; stall = 0; redirect = 0; redirect_pc = 16'h0; resume = 0;
      repeat (3) tick;
      #1 chk("lit_rst_pc", {16'h0, pc}, 32'h0);
      tick; resetn = 1;
      #1 chk("lit_c0_pc", {16'h0, pc}, 32'h0);
      tick; #1;
      chk("lit_c1_if_pc", {16'h0, if_pc}, 32'h0);
      chk("lit_c1_valid", {31'h0, if_valid}, 32'h1);
      repeat (3) tick;
      #1 chk("lit_c4_if_pc", {16'h0, if_pc}, 32'h3);
      chk("lit_c4_pc", {16'h0, pc}, 32'h4);
      repeat (2) tick;
      stall = 1;
      repeat (3) begin
         #1 chk("lit_stall_pc", {16'h0, pc}, 32'h5);
         chk("lit_stall_if_pc", {16'h0, if_pc}, 32'h5);
         chk("lit_stall_word", instr_q, 32'h5);
         tick;
      end
      stall = 0;
      tick; #1 chk("lit_unstall_if_pc", {16'h0, if_pc}, 32'h6);
      tick; redirect = 1; redirect_pc = 16'h0040;
      #1 chk("lit_redir_valid", {31'h0, if_valid}, 32'h0);
      chk("lit_redir_if_pc", {16'h0, if_pc}, 32'h7);
      tick; redirect = 0;
      #1 chk("lit_redir_tgt", {16'h0, if_pc}, 32'h40);
      chk("lit_redir_pc", {16'h0, pc}, 32'h41);
      chk("lit_redir_v", {31'h0, if_valid}, 32'h1);
      // halt word at 9
      redirect = 1; redirect_pc = 16'h0008; tick; redirect = 0;
      tick; #1 chk("lit_halt_word_valid", {31'h0, if_valid}, 32'h1);
      chk("lit_halt_word", instr_q, 32'hFFFF_FFFF);
      tick;
      repeat (10) begin
         #1 chk("lit_halted", {31'h0, halted}, 32'h1);
         chk("lit_halted_valid", {31'h0, if_valid}, 32'h0);
         tick;
      end
      resume = 1; tick; resume = 0;
      #1 chk("lit_resume_if_pc", {16'h0, if_pc}, 32'hA);
      chk("lit_resume_valid", {31'h0, if_valid}, 32'h1);
      // wrap-around
      redirect = 1; redirect_pc = 16'hFFFF; tick; redirect = 0;
      #1 chk("lit_wrap0", {16'h0, if_pc}, 32'hFFFF);
      tick; #1 chk("lit_wrap1", {16'h0, if_pc}, 32'h0);
      tick; #1 chk("lit_wrap2", {16'h0, if_pc}, 32'h1);
      stall = 1; redirect = 1; redirect_pc = 16'h0020; tick; stall = 0; redirect = 0;
      #1 chk("lit_stall_redir", {16'h0, if_pc}, 32'h20);
      chk("lit_stall_redir_v", {31'h0, if_valid}, 32'h1);
      // async reset mid-halt
      redirect = 1; redirect_pc = 16'h0031; tick; redirect = 0;
      tick; tick; tick;
      #2 chk("lit_pre_rst_halted", {31'h0, halted}, 32'h1);
      resetn = 0;
      #1 chk("lit_arst_halted", {31'h0, halted}, 32'h0);
      chk("lit_arst_pc", {16'h0, pc}, 32'h0);
      chk("lit_arst_valid", {31'h0, if_valid}, 32'h0);
      tick; tick; resetn = 1;
      // async reset mid-stall
      tick; tick; stall = 1; tick; tick;
      #2 resetn = 0;
      #1 chk("lit_arst2_pc", {16'h0, pc}, 32'h0);
      chk("lit_arst2_valid", {31'h0, if_valid}, 32'h0);
      tick; stall = 0; resetn = 1;
`ifdef PC_FETCH_PERF_EN
      resetn = 0; tick; resetn = 1;
      tick; stall = 1; tick; tick; stall = 0;
      repeat (5) tick;
      #1 chk("lit_fetch5", fetch_count, 32'd5);
      chk("lit_stall2", stall_count, 32'd2);
`endif
      // randomized stimulus
      repeat (3000) begin
         tick;
         stall       = ($urandom_range(0, 9) < 3);
         redirect    = ($urandom_range(0, 99) < 8);
         redirect_pc = ($urandom_range(0, 9) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                   : 16'($urandom_range(0, 16'h60));
         resume      = ($urandom_range(0, 4) == 0);
      end
      tick; stall = 0; redirect = 0; resume = 0;
      tick; tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
